// File: rtl/data_memory_responder_if.sv
// CPU data-memory port bundle: the CPU is the master, the memory responder is the slave.
// MEM_ERROR exists only when DMEM_MISALIGN_CHECK_EN is defined.
interface data_memory_responder_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  MEM_FUNCT3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        MEM_ERROR;
`endif

  // Handshake: a request is exactly one of MEM_READ/MEM_WRITE high; the CPU
  // holds it while BUSYWAIT=1 and may advance in the first cycle BUSYWAIT=0.
  modport master (
    output MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA,
`ifdef DMEM_MISALIGN_CHECK_EN
    input  MEM_ERROR,
`endif
    input  READ_DATA, BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITE_DATA,
`ifdef DMEM_MISALIGN_CHECK_EN
    output MEM_ERROR,
`endif
    output READ_DATA, BUSYWAIT
  );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle RV32 data memory responder (IDLE -> ACCESS -> ACK) with byte/half/word lanes.
// Optional misaligned-access detection and MEM_ERROR output under DMEM_MISALIGN_CHECK_EN.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  data_memory_responder_if.slave bus,
  output logic [1:0]            state_dbg
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic                  op_write_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           read_data_q;
  logic [31:0]           mem [0:DEPTH-1];

  logic                  req;
  logic                  execute;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            off;
  logic [31:0]           rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_value;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic                  size_half;
  logic                  size_word;
  logic                  misalign;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.MEM_ADDRESS[31:ADDR_WIDTH+2];

  assign req          = bus.MEM_READ ^ bus.MEM_WRITE;
  assign execute      = (state == ACCESS) && (cnt == '0);
  assign bus.BUSYWAIT = ((state == IDLE) && req) || (state == ACCESS);
  assign bus.READ_DATA = read_data_q;
  assign state_dbg    = state;

  assign widx    = addr_q[ADDR_WIDTH+1:2];
  assign off     = addr_q[1:0];
  assign rd_word = mem[widx];
  assign ld_byte = rd_word[8*off +: 8];
  assign ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  // Loads decode size from funct3[1:0]; stores treat every code above SH as a word.
  assign size_half = op_write_q ? (f3_q == 3'b001) : (f3_q[1:0] == 2'b01);
  assign size_word = op_write_q ? (f3_q[2:1] != 2'b00) : f3_q[1];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = (size_half && off[0]) || (size_word && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    ld_value = rd_word;
    case (f3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = rd_word;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    if (size_half) begin
      be    = addr_q[1] ? 4'b1100 : 4'b0011;
      wlane = {2{wdata_q[15:0]}};
    end else if (!size_word) begin
      be    = 4'b0001 << off;
      wlane = {4{wdata_q[7:0]}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      read_data_q <= '0;
      op_write_q  <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_write_q <= bus.MEM_WRITE;
            f3_q       <= bus.MEM_FUNCT3;
            addr_q     <= bus.MEM_ADDRESS[ADDR_WIDTH+1:0];
            wdata_q    <= bus.MEM_WRITE_DATA;
            cnt        <= CW'(LATENCY - 1);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!op_write_q) read_data_q <= misalign ? 32'd0 : ld_value;
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the array: RESET only aborts a pending store by gating it here.
  always_ff @(posedge CLK) begin
    if (!RESET && execute && op_write_q && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RESET) bus.MEM_ERROR <= 1'b0;
    else       bus.MEM_ERROR <= execute && misalign;
  end
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed lane/wrap/reset cases plus random traffic,
// checked every cycle against a transaction-level memory model.
module tb_data_memory_responder;
  localparam int LAT   = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;

  data_memory_responder_if bus();

  data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK(clk), .RESET(rst), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] exp_q[$];
  logic        exp_busy  = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err   = 1'b0;
  bit          chk_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %08h expected %08h", name, got, exp);
    else n_pass++;
  endtask

  // Per-cycle compare of the registered and combinational outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busywait", {31'd0, bus.BUSYWAIT}, {31'd0, exp_busy});
      check("read_data", bus.READ_DATA, exp_rdata);
`ifdef DMEM_MISALIGN_CHECK_EN
      check("mem_error", {31'd0, bus.MEM_ERROR}, {31'd0, exp_err});
`endif
    end
  end

  // ---- behavioural model ----
  function automatic int acc_size(input bit wr, input logic [2:0] f3);
    if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(input bit wr, input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return (a % acc_size(wr, f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_index(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, v;
    int sz, off;
    w   = model_mem[word_index(a)];
    sz  = acc_size(1'b0, f3);
    off = int'(a % 4);
    if (is_misaligned(1'b0, f3, a)) return 32'd0;
    if (sz == 1) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sz, sh;
    sz = acc_size(1'b1, f3);
    if (is_misaligned(1'b1, f3, a)) return;
    if (sz == 1)      begin mask = 32'hFF;   sh = 8 * int'(a % 4); end
    else if (sz == 2) begin mask = 32'hFFFF; sh = 16 * int'((a % 4) / 2); end
    else              begin mask = 32'hFFFF_FFFF; sh = 0; end
    mask = mask << sh;
    model_mem[word_index(a)] = (model_mem[word_index(a)] & ~mask) | ((d << sh) & mask);
  endfunction

  // ---- driver ----
  task automatic txn(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] got, output int busy_cycles);
    logic [31:0] ld_exp;
    bit          mis;
    ld_exp = model_load(f3, a);
    mis    = is_misaligned(wr, f3, a);
    busy_cycles = 0;
    got = 32'd0;
    for (int c = 0; c <= LAT + 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.MEM_READ = !wr; bus.MEM_WRITE = wr;
        bus.MEM_FUNCT3 = f3; bus.MEM_ADDRESS = a; bus.MEM_WRITE_DATA = d;
        exp_busy = 1'b1;
      end else if (c <= LAT) begin
        bus.MEM_FUNCT3 = 3'($urandom); bus.MEM_ADDRESS = $urandom;
        bus.MEM_WRITE_DATA = $urandom;
        exp_busy = 1'b1;
      end else if (c == LAT + 1) begin
        exp_busy = 1'b0;
        exp_err  = mis;
        if (wr) model_store(f3, a, d);
        else begin
          exp_rdata = ld_exp;
          exp_q.push_back(ld_exp);
        end
      end else begin
        bus.MEM_READ = 1'b0; bus.MEM_WRITE = 1'b0;
        exp_err = 1'b0;
      end
      #1;
      if (bus.BUSYWAIT) busy_cycles++;
      if (c == LAT + 1) got = bus.READ_DATA;
    end
    if (!wr && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  logic [31:0] got;
  int          bc;

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    bus.MEM_READ = 1'b0; bus.MEM_WRITE = 1'b0; bus.MEM_FUNCT3 = 3'd0;
    bus.MEM_ADDRESS = 32'd0; bus.MEM_WRITE_DATA = 32'd0;

    rst = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, bc);
    check("sw_busy_cycles", bc, 32'd5);
    txn(1'b0, 3'b010, 32'h10, 32'h0, got, bc);
    check("lw_0x10", got, 32'hDEADBEEF);

    txn(1'b1, 3'b010, 32'h20, 32'h0, got, bc);
    txn(1'b1, 3'b000, 32'h23, 32'hF0, got, bc);
    txn(1'b1, 3'b001, 32'h20, 32'h8001, got, bc);
    txn(1'b0, 3'b010, 32'h20, 32'h0, got, bc); check("lw_0x20", got, 32'hF0008001);
    txn(1'b0, 3'b000, 32'h23, 32'h0, got, bc); check("lb_0x23", got, 32'hFFFFFFF0);
    txn(1'b0, 3'b100, 32'h23, 32'h0, got, bc); check("lbu_0x23", got, 32'h000000F0);
    txn(1'b0, 3'b001, 32'h20, 32'h0, got, bc); check("lh_0x20", got, 32'hFFFF8001);
    txn(1'b0, 3'b101, 32'h20, 32'h0, got, bc); check("lhu_0x20", got, 32'h00008001);

    txn(1'b1, 3'b010, 32'h400, 32'h12345678, got, bc);
    txn(1'b0, 3'b010, 32'h000, 32'h0, got, bc); check("wrap_lw_0x0", got, 32'h12345678);

    // Both request lines high: must be ignored entirely.
    @(posedge clk); #1;
    bus.MEM_READ = 1'b1; bus.MEM_WRITE = 1'b1; bus.MEM_FUNCT3 = 3'b010;
    bus.MEM_ADDRESS = 32'h10; bus.MEM_WRITE_DATA = 32'h55555555; exp_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1; bus.MEM_READ = 1'b0; bus.MEM_WRITE = 1'b0;
    txn(1'b0, 3'b010, 32'h10, 32'h0, got, bc); check("illegal_kept_0x10", got, 32'hDEADBEEF);

    // Reset during the second ACCESS cycle of a store.
    txn(1'b1, 3'b010, 32'h30, 32'h0, got, bc);
    @(posedge clk); #1;
    bus.MEM_WRITE = 1'b1; bus.MEM_FUNCT3 = 3'b010; bus.MEM_ADDRESS = 32'h30;
    bus.MEM_WRITE_DATA = 32'hAAAAAAAA; exp_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; bus.MEM_WRITE = 1'b0;
    exp_busy = 1'b0; exp_rdata = 32'd0; exp_err = 1'b0;
    #1; check("rst_abort_busy", {31'd0, bus.BUSYWAIT}, 32'd0);
    txn(1'b0, 3'b010, 32'h30, 32'h0, got, bc); check("lw_0x30_after_abort", got, 32'h0);

`ifdef DMEM_MISALIGN_CHECK_EN
    txn(1'b1, 3'b010, 32'h30, 32'h11111111, got, bc);
    txn(1'b0, 3'b010, 32'h31, 32'h0, got, bc); check("misaligned_lw_0x31", got, 32'h0);
    txn(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, got, bc);
    txn(1'b1, 3'b001, 32'h41, 32'h1234, got, bc);
    txn(1'b0, 3'b010, 32'h40, 32'h0, got, bc); check("sh_0x41_suppressed", got, 32'hCAFEF00D);
`else
    txn(1'b1, 3'b010, 32'h30, 32'h11223344, got, bc);
    txn(1'b0, 3'b010, 32'h31, 32'h0, got, bc); check("lw_0x31_ignores_low", got, 32'h11223344);
    txn(1'b0, 3'b001, 32'h33, 32'h0, got, bc); check("lh_0x33_upper_lane", got, 32'h00001122);
`endif

    // Random traffic over a small set of pre-initialised words, random upper address bits.
    for (int i = 0; i < 16; i++) txn(1'b1, 3'b010, 32'(i << 2), 32'h0, got, bc);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got, bc);
    end

    repeat (2) @(posedge clk);
    #1; chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
